// File: rtl/i2s_frame_reader.sv
// Bit-serial reader for the I2S circular frame RAM: fetches each completed 256-bit frame,
// rebuilds its eight 32-bit slots and streams MSB-justified samples out over valid/ready.
module i2s_frame_reader #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int SAMPLE_BITS   = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
  output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
  output logic                     ram_read_en_o,
  input  logic                     ram_read_data_i,
  output logic [SAMPLE_BITS-1:0]   sample_o,
  output logic [2:0]               channel_o,
  output logic                     last_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [CIRC_BUF_BITS-1:0] frame_idx_o,
  output logic                     overrun_o
);
  localparam int FW = CIRC_BUF_BITS;
  localparam logic [FW-1:0] SKIP_THRESH = FW'((1 << FW) - 2);

  typedef enum logic [1:0] {SYNC, IDLE, READ} state_e;

  state_e                 state_q, state_d;
  logic [FW-1:0]          last_read_q, last_read_d;
  logic [FW-1:0]          target_q, target_d;
  logic [7:0]             bit_cnt_q, bit_cnt_d;
  logic                   pend_q, pend_d;
  logic [7:0]             pend_bit_q, pend_bit_d;
  logic [FW-1:0]          pend_frame_q, pend_frame_d;
  logic [30:0]            asm_q, asm_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [SAMPLE_BITS-1:0] hold_sample_q, hold_sample_d;
  logic [2:0]             hold_chan_q, hold_chan_d;
  logic [FW-1:0]          hold_frame_q, hold_frame_d;
  logic                   out_valid_q, out_valid_d;
  logic [SAMPLE_BITS-1:0] out_sample_q, out_sample_d;
  logic [2:0]             out_chan_q, out_chan_d;
  logic                   out_last_q, out_last_d;
  logic [FW-1:0]          out_frame_q, out_frame_d;
  logic                   overrun_q, overrun_d;

  logic          out_free, stall, issue, word_done, skip;
  logic [31:0]   word;
  logic [FW-1:0] base_frame, gap, next_target;

  assign out_free  = !out_valid_q || ready_i;
  assign stall     = hold_valid_q && !out_free;
  assign issue     = (state_q == READ) && !stall;
  assign word      = {asm_q, ram_read_data_i};
  assign word_done = pend_q && (pend_bit_q[4:0] == 5'd31);

  // At a frame boundary the frame just finished (target_q) becomes the new last-read index.
  assign base_frame  = (state_q == READ) ? target_q : last_read_q;
  assign gap         = last_good_frame_idx_i - base_frame;
  assign skip        = (gap >= SKIP_THRESH);
  assign next_target = skip ? last_good_frame_idx_i : base_frame + FW'(1);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    state_d       = state_q;
    last_read_d   = last_read_q;
    target_d      = target_q;
    bit_cnt_d     = bit_cnt_q;
    pend_d        = 1'b0;
    pend_bit_d    = pend_bit_q;
    pend_frame_d  = pend_frame_q;
    asm_d         = asm_q;
    hold_valid_d  = hold_valid_q;
    hold_sample_d = hold_sample_q;
    hold_chan_d   = hold_chan_q;
    hold_frame_d  = hold_frame_q;
    out_valid_d   = out_valid_q;
    out_sample_d  = out_sample_q;
    out_chan_d    = out_chan_q;
    out_last_d    = out_last_q;
    out_frame_d   = out_frame_q;
    overrun_d     = 1'b0;

    case (state_q)
      SYNC: begin
        last_read_d = last_good_frame_idx_i;
        state_d     = IDLE;
      end
      IDLE: begin
        if (gap != '0) begin
          state_d   = READ;
          bit_cnt_d = '0;
          target_d  = next_target;
          overrun_d = skip;
        end
      end
      READ: begin
        if (issue) begin
          pend_d       = 1'b1;
          pend_bit_d   = bit_cnt_q;
          pend_frame_d = target_q;
          bit_cnt_d    = bit_cnt_q + 8'd1;
          if (bit_cnt_q == 8'd255) begin
            last_read_d = target_q;
            if (gap == '0) begin
              state_d = IDLE;
            end else begin
              target_d  = next_target;
              overrun_d = skip;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (pend_q) asm_d = word[30:0];

    if (out_free) begin
      out_valid_d = hold_valid_q;
      if (hold_valid_q) begin
        out_sample_d = hold_sample_q;
        out_chan_d   = hold_chan_q;
        out_last_d   = (hold_chan_q == 3'd7);
        out_frame_d  = hold_frame_q;
        hold_valid_d = 1'b0;
      end
    end

    // A finished word bypasses the holding register when the output stage can take it now.
    if (word_done) begin
      if (out_free && !hold_valid_q) begin
        out_valid_d  = 1'b1;
        out_sample_d = word[31 -: SAMPLE_BITS];
        out_chan_d   = pend_bit_q[7:5];
        out_last_d   = (pend_bit_q[7:5] == 3'd7);
        out_frame_d  = pend_frame_q;
      end else begin
        hold_valid_d  = 1'b1;
        hold_sample_d = word[31 -: SAMPLE_BITS];
        hold_chan_d   = pend_bit_q[7:5];
        hold_frame_d  = pend_frame_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the data registers are reset too because the output fields must read zero out of reset.
      state_q       <= SYNC;
      last_read_q   <= '0;
      target_q      <= '0;
      bit_cnt_q     <= '0;
      pend_q        <= 1'b0;
      pend_bit_q    <= '0;
      pend_frame_q  <= '0;
      asm_q         <= '0;
      hold_valid_q  <= 1'b0;
      hold_sample_q <= '0;
      hold_chan_q   <= '0;
      hold_frame_q  <= '0;
      out_valid_q   <= 1'b0;
      out_sample_q  <= '0;
      out_chan_q    <= '0;
      out_last_q    <= 1'b0;
      out_frame_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
      state_q       <= state_d;
      last_read_q   <= last_read_d;
      target_q      <= target_d;
      bit_cnt_q     <= bit_cnt_d;
      pend_q        <= pend_d;
      pend_bit_q    <= pend_bit_d;
      pend_frame_q  <= pend_frame_d;
      asm_q         <= asm_d;
      hold_valid_q  <= hold_valid_d;
      hold_sample_q <= hold_sample_d;
      hold_chan_q   <= hold_chan_d;
      hold_frame_q  <= hold_frame_d;
      out_valid_q   <= out_valid_d;
      out_sample_q  <= out_sample_d;
      out_chan_q    <= out_chan_d;
      out_last_q    <= out_last_d;
      out_frame_q   <= out_frame_d;
      overrun_q     <= overrun_d;
    end
  end

  assign ram_read_addr_o = {target_q, bit_cnt_q};
  assign ram_read_en_o   = issue;
  assign sample_o        = out_sample_q;
  assign channel_o       = out_chan_q;
  assign last_o          = out_last_q;
  assign valid_o         = out_valid_q;
  assign frame_idx_o     = out_frame_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_i2s_frame_reader.sv
// Directed bench for i2s_frame_reader: a bit-wide RAM model preloaded with known slot words
// and a scoreboard of the samples each frame must produce.
module tb_i2s_frame_reader;
  localparam int CB = 3;
  localparam int SB = 24;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [CB-1:0] last_good;
  logic [CB+7:0] addr;
  logic          en;
  logic          rdata = 1'b0;
  logic [SB-1:0] sample;
  logic [2:0]    channel;
  logic          last;
  logic          valid;
  logic          ready;
  logic [CB-1:0] frame_idx;
  logic          overrun;

  typedef struct packed {
    logic [2:0]  frame;
    logic [2:0]  chan;
    logic [23:0] sample;
  } exp_t;

  exp_t exp_q[$];
  logic mem [0:2047];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt, ovr_cnt, word_cnt, first_en, last_en, first_valid;
  int ready_mode = 0;  // 0: always ready, 1: ~30% low at random, 2: held low

  logic          prev_stall = 1'b0;
  logic [SB-1:0] prev_sample;
  logic [2:0]    prev_chan;
  logic          prev_last;
  logic [CB-1:0] prev_frame;

  i2s_frame_reader #(.CIRC_BUF_BITS(CB), .SAMPLE_BITS(SB)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_i),
    .last_good_frame_idx_i (last_good),
    .ram_read_addr_o       (addr),
    .ram_read_en_o         (en),
    .ram_read_data_i       (rdata),
    .sample_o              (sample),
    .channel_o             (channel),
    .last_o                (last),
    .valid_o               (valid),
    .ready_i               (ready),
    .frame_idx_o           (frame_idx),
    .overrun_o             (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: data for an enabled read appears one cycle later, noise otherwise.
  always @(posedge clk) begin
    if (en) rdata <= mem[addr];
    else    rdata <= 1'($urandom);
  end

  // Slot word: frame 6 carries 0xA0000000|n<<8, other frames add (f^6)<<16; low byte is dropped.
  function automatic logic [31:0] word_of(input int f, input int n);
    return 32'hA000_0000 | (32'(f ^ 6) << 16) | (32'(n) << 8) | 32'h0000_003C;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; ovr_cnt = 0; word_cnt = 0;
    first_en = -1; last_en = -1; first_valid = -1;
  endtask

  task automatic push_frame(input int f, input int nwords);
    logic [31:0] w;
    exp_t e;
    for (int n = 0; n < nwords; n++) begin
      w = word_of(f, n);
      e.frame  = 3'(f);
      e.chan   = 3'(n);
      e.sample = w[31:8];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int k = 0;
    while (word_cnt < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, word_cnt, n);
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 99) >= 30);
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard on accepted words, stability while stalled, activity counters.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (en) begin
          en_cnt++;
          if (first_en < 0) first_en = cyc;
          last_en = cyc;
        end
        if (overrun) ovr_cnt++;
        if (valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
          check("stall_valid", valid, 1);
          check("stall_sample", sample, prev_sample);
          check("stall_channel", channel, prev_chan);
          check("stall_last", last, prev_last);
          check("stall_frame", frame_idx, prev_frame);
        end
        if (valid && ready) begin
          check("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sample", sample, e.sample);
            check("channel", channel, e.chan);
            check("last", last, e.chan == 3'd7);
            check("frame_idx", frame_idx, e.frame);
          end
          word_cnt++;
        end
        prev_stall  = valid && !ready;
        prev_sample = sample;
        prev_chan   = channel;
        prev_last   = last;
        prev_frame  = frame_idx;
      end
    end
  end

  initial begin
    int k;
    logic [31:0] w;
    for (int f = 0; f < 8; f++)
      for (int n = 0; n < 8; n++) begin
        w = word_of(f, n);
        for (int b = 0; b < 32; b++) mem[f*256 + n*32 + b] = w[31-b];
      end

    rst_i = 1'b1;
    last_good = 3'd5;
    clear_stats();
    tick(3);
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_en", en, 0);
    check("rst_addr", addr, 0);
    check("rst_overrun", overrun, 0);
    check("rst_sample", sample, 0);
    check("rst_channel", channel, 0);
    check("rst_last", last, 0);
    check("rst_frame", frame_idx, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Frame 5 was already complete at reset, so nothing may be read.
    clear_stats();
    tick(300);
    check("idle_reads", en_cnt, 0);
    check("idle_words", word_cnt, 0);
    check("idle_overrun", ovr_cnt, 0);

    // Single frame 6, ready held high.
    clear_stats();
    push_frame(6, 8);
    last_good = 3'd6;
    wait_words("f6_words", 8, 600);
    tick(5);
    check("f6_latency", first_valid - first_en, 33);
    check("f6_reads", en_cnt, 256);
    check("f6_overrun", ovr_cnt, 0);

    // Frames 7 and 0 back-to-back across the index wrap.
    clear_stats();
    push_frame(7, 8);
    push_frame(0, 8);
    last_good = 3'd7;
    tick(100);
    last_good = 3'd0;
    wait_words("b2b_words", 16, 1000);
    tick(5);
    check("b2b_reads", en_cnt, 512);
    check("b2b_span", last_en - first_en + 1, 512);

    // Frame 1 under backpressure: reads for bits 0..64 go out before the holding register
    // fills behind a stuck output word, then issue pauses until ready returns.
    clear_stats();
    push_frame(1, 8);
    ready_mode = 2;
    last_good = 3'd1;
    tick(150);
    check("bp_paused_reads", en_cnt, 65);
    ready_mode = 1;
    wait_words("bp_words", 8, 3000);
    ready_mode = 0;
    tick(5);
    check("bp_reads", en_cnt, 256);

    // last_read=0, last_good jumps to 6: skip straight to frame 6 with one overrun pulse.
    rst_i = 1'b1;
    last_good = 3'd0;
    tick(2);
    rst_i = 1'b0;
    tick(5);
    clear_stats();
    push_frame(6, 8);
    last_good = 3'd6;
    wait_words("ovr_words", 8, 600);
    tick(5);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_reads", en_cnt, 256);

    // d=5 is just below the skip threshold: frames 7,0,1,2,3 all read, no overrun.
    clear_stats();
    push_frame(7, 8);
    for (int f = 0; f < 4; f++) push_frame(f, 8);
    last_good = 3'd3;
    wait_words("d5_words", 40, 1500);
    tick(5);
    check("d5_overrun", ovr_cnt, 0);
    check("d5_reads", en_cnt, 1280);
    check("d5_span", last_en - first_en + 1, 1280);

    // Reset at bit 100 of frame 4: only slots 0..2 are out by then.
    clear_stats();
    push_frame(4, 3);
    last_good = 3'd4;
    k = 0;
    while (en_cnt < 100 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_reads", en_cnt, 100);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_en", en, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("mid_words", word_cnt, 3);
    clear_stats();
    tick(300);
    check("post_rst_reads", en_cnt, 0);
    push_frame(5, 8);
    last_good = 3'd5;
    wait_words("post_rst_words", 8, 600);
    tick(5);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_frame_reader.md
Name: i2s_frame_reader

Overview:
- Downstream consumer of the I2S MSB-first bit receiver's circular frame buffer.
- Reads completed 256-bit frames (8 slots × 32 bits) bit-serially from the 1-bit-wide frame RAM's read port.
- Reassembles the slots into MSB-justified samples and presents them on a valid/ready stream for the USB/ADAT packetiser.
- Tracks the writer's last-good-frame index and skips ahead when the writer is about to lap the reader.

Parameters:
- CIRC_BUF_BITS, 3, log2 of the number of 256-bit frames in the RAM; must match the writer.
- SAMPLE_BITS, 24, sample width; the top SAMPLE_BITS of each 32-bit slot, range 1..32.

Ports:
- clk_i  in  1  system clock, same domain as the writer
- rst_i  in  1  synchronous reset, active-high
- last_good_frame_idx_i  in  CIRC_BUF_BITS  index of the newest fully written frame
- ram_read_addr_o  out  CIRC_BUF_BITS+8  {frame, bit}; bit 0 is the MSB of slot 0
- ram_read_en_o  out  1  read strobe
- ram_read_data_i  in  1  RAM data, valid exactly 1 cycle after an enabled read
- sample_o  out  SAMPLE_BITS  slot bits [31:32-SAMPLE_BITS]
- channel_o  out  3  slot number 0..7
- last_o  out  1  high with channel 7
- valid_o  out  1  output word valid
- ready_i  in  1  consumer accepts when valid_o && ready_i
- frame_idx_o  out  CIRC_BUF_BITS  frame index the current word came from
- overrun_o  out  1  one-cycle pulse when frames are skipped

Behaviour:
- Reset (synchronous, rst_i high): valid_o=0, ram_read_en_o=0, ram_read_addr_o=0, overrun_o=0, sample_o=0, channel_o=0, last_o=0, frame_idx_o=0.
  - State goes to SYNC; all in-flight reads are discarded.
  - Reset mid-frame drops the partial frame with no output.
- SYNC: one cycle. Captures last_read_r <= last_good_frame_idx_i, so no stale frame is read. Then goes to IDLE.
- IDLE: d = (last_good_frame_idx_i - last_read_r) mod 2^CIRC_BUF_BITS.
  - d==0: stay in IDLE.
  - 1 <= d <= 2^CIRC_BUF_BITS-3: target = last_read_r+1, go to READ.
  - d >= 2^CIRC_BUF_BITS-2: target = last_good_frame_idx_i, pulse overrun_o for 1 cycle, go to READ.
- READ: issues ram_read_en_o=1 with addr {target, bit_cnt}, bit_cnt 0→255.
  - Data returned 1 cycle later shifts MSB-first into a 32-bit assembler.
  - Every 32 bits, the word goes to a holding register, tagged with channel = bit_cnt[7:5] of its bits and frame = target.
- Output register: loads from the holding register when empty or being accepted that cycle.
  - sample_o/channel_o/last_o/frame_idx_o stay stable while valid_o && !ready_i.
- Backpressure: read issue pauses (ram_read_en_o=0, address held) only when the holding register is full and cannot drain.
  - No bit is dropped, duplicated or reordered.
  - The read in flight at the moment of the pause must still be captured.
- End of frame: after address bit 255 is issued, last_read_r <= target.
  - If the next frame is already available (same d rule), the first address of the next frame is issued on the very next cycle with no bubble.
  - Otherwise go to IDLE.
- With ready_i held high: steady state is 256 read cycles per frame and zero bubbles, i.e. one sample every 32 cycles.
- Wrap-around: frame index arithmetic is modulo 2^CIRC_BUF_BITS; the bit counter wraps 255→0.
- Simultaneous events: if last_good_frame_idx_i changes during READ, it is only re-evaluated at the frame boundary. The overrun check is evaluated only at frame start.
- ram_read_en_o is never asserted in SYNC, or in IDLE with d==0.
- Latency: the first sample_o is valid 33 cycles after the first read of a frame (32 reads + 1 RAM latency).

Test Plan:
- Reset then last_good_frame_idx_i held at 5 → no reads, valid_o stays 0, overrun_o stays 0.
- RAM frame 6 filled with slot n = 0xA0000000|n<<8, last_good 5→6, ready_i=1 → 8 words with sample_o=0xA0000n, channel_o 0..7, last_o only on 7, frame_idx_o=6, first valid_o 33 cycles after the first read.
- last_good stepped 6→7→0 every 256 cycles, ready_i=1 → frames 7 and 0 read back-to-back, no address gap, 16 words in order.
- ready_i toggled pseudo-randomly 30% low during a frame → output word sequence identical to the ready_i=1 case; outputs stable while stalled.
- last_read=0, last_good jumps to 6 (d=6, CIRC_BUF_BITS=3) → one overrun_o pulse, frame 6 read, frames 1–5 skipped.
- rst_i asserted at bit 100 of a frame → next cycle valid_o=0 and ram_read_en_o=0; after SYNC, only newly completed frames are read.
